// File: rtl/pad_mux_pkg.sv
// rtl/pad_mux_pkg.sv - shared constants and FSM state type for the pad mux controller
package pad_mux_pkg;

    localparam int N_SEL_DEFAULT = 4;
    localparam int SEL_W         = $clog2(N_SEL_DEFAULT);

    localparam logic [11:0] PADMUX_BASE = 12'h000;
    localparam logic [11:0] STATUS_OFF  = 12'h400;

    localparam int CFG_LSB  = 8;
    localparam int BUSY_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        COMMIT
    } state_e;

endpackage

// File: rtl/pad_mux_switch_fsm.sv
// rtl/pad_mux_switch_fsm.sv - guarded source switchover sequencer (oe blanking, then commit)
module pad_mux_switch_fsm
    import pad_mux_pkg::*;
#(
    parameter int N_IO         = 48,
    parameter int SW           = 2,
    parameter int IW           = 6,
    parameter int GUARD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IW-1:0]   start_idx,
    input  logic [SW-1:0]   start_sel,
    output state_e          state,
    output logic [IW-1:0]   pend_idx,
    output logic [SW-1:0]   pend_sel,
    output logic            busy,
    output logic            commit,
    output logic [N_IO-1:0] blank
);

    localparam int CW = $clog2(GUARD_CYCLES + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_idx <= '0;
            pend_sel <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start && state_q == IDLE) begin
                pend_idx <= start_idx;
                pend_sel <= start_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BLANK;
                    cnt_d   = CW'(GUARD_CYCLES - 1);
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;

    // Only the pad under switchover loses its output enable.
    for (genvar i = 0; i < N_IO; i++) begin : g_blank
        assign blank[i] = (state_q == BLANK) && (pend_idx == IW'(i));
    end

endmodule

// File: rtl/pad_mux_ctrl.sv
// rtl/pad_mux_ctrl.sv - APB register file, pad source muxing and pad config for the pad frame
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int N_IO         = 48,
    parameter int NBIT_PADCFG  = 6,
    parameter int N_SEL        = N_SEL_DEFAULT,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        apb_psel_i,
    input  logic                        apb_penable_i,
    input  logic                        apb_pwrite_i,
    input  logic [11:0]                 apb_paddr_i,
    input  logic [31:0]                 apb_pwdata_i,
    output logic [31:0]                 apb_prdata_o,
    output logic                        apb_pready_o,
    output logic                        apb_pslverr_o,
    input  logic [N_IO*N_SEL-1:0]       src_out_i,
    input  logic [N_IO*N_SEL-1:0]       src_oe_i,
    output logic [N_IO-1:0]             io_out_o,
    output logic [N_IO-1:0]             io_oe_o,
    output logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_o,
    output logic                        busy_o
);

    localparam int SW = $clog2(N_SEL);
    localparam int IW = $clog2(N_IO);

    logic [SW-1:0]          sel_q [N_IO];
    logic [NBIT_PADCFG-1:0] cfg_q [N_IO];

    state_e          state;
    logic            busy, commit;
    logic [IW-1:0]   pend_idx;
    logic [SW-1:0]   pend_sel;
    logic [N_IO-1:0] blank;

    logic          access, idle, is_pad, is_status, sel_bad, wr_ok, start, err;
    logic [11:0]   rel_addr;
    logic [IW-1:0] pad_idx;
    logic [SW-1:0] new_sel;
    logic [31:0]   rdata;

    assign access    = apb_psel_i & apb_penable_i;
    assign idle      = (state == IDLE);
    assign rel_addr  = apb_paddr_i - PADMUX_BASE;
    assign is_pad    = (rel_addr[1:0] == 2'b00) && (rel_addr[11:2] < 10'(N_IO));
    assign is_status = (apb_paddr_i == STATUS_OFF);
    assign pad_idx   = rel_addr[2 +: IW];
    assign new_sel   = apb_pwdata_i[SW-1:0];
    // The whole byte below the cfg field is checked so out-of-range selects are rejected.
    assign sel_bad   = apb_pwdata_i[CFG_LSB-1:0] >= CFG_LSB'(N_SEL);

    assign err   = access & idle & (apb_pwrite_i ? (~is_pad | sel_bad) : ~(is_pad | is_status));
    assign wr_ok = access & idle & apb_pwrite_i & is_pad & ~sel_bad;
    assign start = wr_ok & (new_sel != sel_q[pad_idx]);

    // A reselecting write is held off until the commit cycle.
    assign apb_pready_o  = idle ? ~start : commit;
    assign apb_pslverr_o = err;
    assign busy_o        = busy;

    always_comb begin
        rdata = '0;
        if (is_status) begin
            rdata[BUSY_BIT] = busy;
            rdata[13:8]     = 6'(pend_idx);
        end else if (is_pad) begin
            rdata[SW-1:0]                   = sel_q[pad_idx];
            rdata[CFG_LSB +: NBIT_PADCFG]   = cfg_q[pad_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            apb_prdata_o <= '0;
        end else if (access && !apb_pwrite_i) begin
            apb_prdata_o <= rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_IO; i++) begin
                sel_q[i] <= '0;
                cfg_q[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                cfg_q[pad_idx] <= apb_pwdata_i[CFG_LSB +: NBIT_PADCFG];
            end
            if (commit) begin
                sel_q[pend_idx] <= pend_sel;
            end
        end
    end

    pad_mux_switch_fsm #(
        .N_IO         (N_IO),
        .SW           (SW),
        .IW           (IW),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_switch_fsm (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .start     (start),
        .start_idx (pad_idx),
        .start_sel (new_sel),
        .state     (state),
        .pend_idx  (pend_idx),
        .pend_sel  (pend_sel),
        .busy      (busy),
        .commit    (commit),
        .blank     (blank)
    );

    for (genvar i = 0; i < N_IO; i++) begin : g_pad
        logic [N_SEL-1:0] outs, oes;
        assign outs        = src_out_i[i*N_SEL +: N_SEL];
        assign oes         = src_oe_i[i*N_SEL +: N_SEL];
        assign io_out_o[i] = outs[sel_q[i]];
        assign io_oe_o[i]  = oes[sel_q[i]] & ~blank[i];
        assign pad_cfg_o[i*NBIT_PADCFG +: NBIT_PADCFG] = cfg_q[i];
    end

    logic unused_pwdata;
    assign unused_pwdata = ^apb_pwdata_i[31:CFG_LSB+NBIT_PADCFG];

endmodule
